// File: rtl/swd_target_responder.sv
// SWD DP-side target: line reset, request/ACK/data phases, DP registers and a valid/ready AP port.
// Define SWD_TGT_STICKY_ERR_EN to enable the sticky WDATAERR bit and FAULT responses.
module swd_target_responder #(
    parameter logic [31:0] IDCODE_VAL  = 32'h2BA01477,
    parameter int          LRESET_ONES = 50
) (
    input  logic        swclk,
    input  logic        rst,
    input  logic        swdio_in,
    output logic        swdio_out,
    output logic        swdio_oe,
    output logic        ap_valid,
    input  logic        ap_ready,
    output logic        ap_rnw,
    output logic [7:0]  ap_addr,
    output logic [31:0] ap_wdata,
    input  logic [31:0] ap_rdata,
    output logic        protocol_err
);
`ifdef SWD_TGT_STICKY_ERR_EN
    localparam logic STICKY_EN = 1'b1;
`else
    localparam logic STICKY_EN = 1'b0;
`endif
    localparam logic [5:0] LR_TH     = 6'(LRESET_ONES - 1);
    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    typedef enum logic [3:0] {LOCKOUT, LRESET, IDLE, REQ, TRN1, ACK, RDATA, TRN2, WDATA} state_t;

    state_t      state_q, state_d;
    logic [5:0]  ones_q, ones_d, cnt_q, cnt_d;
    logic [5:0]  req_q, req_d;      // {stop, parity, A3, A2, RnW, APnDP}
    logic [2:0]  ack_q, ack_d;
    logic [31:0] shift_q, shift_d, rdbuf_q, rdbuf_d, last_rd_q, last_rd_d;
    logic        par_q, par_d, oe_q, oe_d, out_q, out_d, perr_q, perr_d;
    logic [1:0]  ctrl_q, ctrl_d;    // power-up request bits 30 and 28
    logic [3:0]  bank_q, bank_d;
    logic        sticky_q, sticky_d, launch_q, launch_d;
    logic        ap_valid_q, ap_valid_d, ap_rnw_q, ap_rnw_d;
    logic [7:0]  ap_addr_q, ap_addr_d;
    logic [31:0] ap_wdata_q, ap_wdata_d;
    logic [31:0] rd_word, ctrlstat;
    logic [2:0]  ack_sel;
    logic [1:0]  a_bits;
    logic        apndp, rnw, ap_hs, fault_exempt;

    assign apndp        = req_q[0];
    assign rnw          = req_q[1];
    assign a_bits       = req_q[3:2];
    assign ap_hs        = ap_valid_q && ap_ready;
    assign fault_exempt = !apndp && (rnw ? !a_bits[1] : (a_bits == 2'd0));
    // Each power-up request is reflected straight into its ack bit one position above.
    assign ctrlstat     = {ctrl_q[1], ctrl_q[1], ctrl_q[0], ctrl_q[0], 20'd0, sticky_q, 7'd0};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        ack_d      = ack_q;
        shift_d    = shift_q;
        par_d      = par_q;
        oe_d       = oe_q;
        out_d      = out_q;
        perr_d     = 1'b0;
        ctrl_d     = ctrl_q;
        bank_d     = bank_q;
        sticky_d   = sticky_q;
        last_rd_d  = last_rd_q;
        launch_d   = 1'b0;
        ap_rnw_d   = ap_rnw_q;
        ap_addr_d  = ap_addr_q;
        ap_wdata_d = ap_wdata_q;
        rd_word    = '0;
        ack_sel    = ACK_OK;
        ones_d     = swdio_in ? ((ones_q == 6'd63) ? ones_q : ones_q + 6'd1) : 6'd0;
        rdbuf_d    = (ap_hs && ap_rnw_q) ? ap_rdata : rdbuf_q;
        ap_valid_d = launch_q ? 1'b1 : (ap_hs ? 1'b0 : ap_valid_q);

        if (swdio_in && ones_q >= LR_TH) begin
            state_d = LRESET;
            oe_d    = 1'b0;
            out_d   = 1'b0;
        end else begin
            case (state_q)
                LRESET: if (!swdio_in) state_d = IDLE;
                IDLE: if (swdio_in) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end
                REQ: begin
                    if (cnt_q != 6'd6) begin
                        req_d = {swdio_in, req_q[5:1]};
                        cnt_d = cnt_q + 6'd1;
                    end else if (req_q[4] != ^req_q[3:0] || req_q[5] || !swdio_in) begin
                        perr_d  = 1'b1;
                        state_d = LOCKOUT;
                    end else begin
                        state_d = TRN1;
                    end
                end
                TRN1: begin
                    case (a_bits)
                        2'd0:    rd_word = IDCODE_VAL;
                        2'd1:    rd_word = ctrlstat;
                        2'd2:    rd_word = last_rd_q;
                        default: rd_word = rdbuf_d;
                    endcase
                    if (apndp) rd_word = rdbuf_d;
                    if (ap_valid_q && !ap_ready)                      ack_sel = ACK_WAIT;
                    else if (STICKY_EN && sticky_q && !fault_exempt) ack_sel = ACK_FAULT;
                    ack_d   = ack_sel;
                    state_d = ACK;
                    cnt_d   = '0;
                    oe_d    = 1'b1;
                    out_d   = ack_sel[0];
                    if (ack_sel == ACK_OK && rnw) begin
                        shift_d   = rd_word;
                        par_d     = ^rd_word;
                        last_rd_d = rd_word;
                        // Posted AP read: the old RDBUFF goes out now, the new access starts.
                        if (apndp) begin
                            launch_d  = 1'b1;
                            ap_rnw_d  = 1'b1;
                            ap_addr_d = {bank_q, a_bits, 2'b00};
                        end
                    end
                end
                ACK: begin
                    if (cnt_q != 6'd2) begin
                        out_d = ack_q[cnt_q[1:0] + 2'd1];
                        cnt_d = cnt_q + 6'd1;
                    end else if (ack_q == ACK_OK && rnw) begin
                        state_d = RDATA;
                        out_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = '0;
                    end else begin
                        state_d = TRN2;
                        oe_d    = 1'b0;
                        out_d   = 1'b0;
                    end
                end
                RDATA: begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q < 6'd31) begin
                        out_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end else if (cnt_q == 6'd31) begin
                        out_d = par_q;
                    end else begin
                        state_d = TRN2;
                        oe_d    = 1'b0;
                        out_d   = 1'b0;
                    end
                end
                TRN2: begin
                    cnt_d   = '0;
                    state_d = (ack_q == ACK_OK && !rnw) ? WDATA : IDLE;
                end
                WDATA: begin
                    if (cnt_q != 6'd32) begin
                        shift_d = {swdio_in, shift_q[31:1]};
                        cnt_d   = cnt_q + 6'd1;
                    end else begin
                        state_d = IDLE;
                        if (swdio_in == ^shift_q) begin
                            if (apndp) begin
                                launch_d   = 1'b1;
                                ap_rnw_d   = 1'b0;
                                ap_addr_d  = {bank_q, a_bits, 2'b00};
                                ap_wdata_d = shift_q;
                            end else begin
                                case (a_bits)
                                    2'd0:    if (shift_q[0]) sticky_d = 1'b0;
                                    2'd1:    ctrl_d = {shift_q[30], shift_q[28]};
                                    2'd2:    bank_d = shift_q[7:4];
                                    default: ;
                                endcase
                            end
                        end else if (STICKY_EN) begin
                            sticky_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge swclk or posedge rst) begin
        if (rst) begin
            state_q    <= LOCKOUT;
            ones_q     <= '0;
            cnt_q      <= '0;
            req_q      <= '0;
            ack_q      <= '0;
            shift_q    <= '0;
            rdbuf_q    <= '0;
            last_rd_q  <= '0;
            par_q      <= 1'b0;
            oe_q       <= 1'b0;
            out_q      <= 1'b0;
            perr_q     <= 1'b0;
            ctrl_q     <= '0;
            bank_q     <= '0;
            sticky_q   <= 1'b0;
            launch_q   <= 1'b0;
            ap_valid_q <= 1'b0;
            ap_rnw_q   <= 1'b0;
            ap_addr_q  <= '0;
            ap_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            ack_q      <= ack_d;
            shift_q    <= shift_d;
            rdbuf_q    <= rdbuf_d;
            last_rd_q  <= last_rd_d;
            par_q      <= par_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            perr_q     <= perr_d;
            ctrl_q     <= ctrl_d;
            bank_q     <= bank_d;
            sticky_q   <= sticky_d;
            launch_q   <= launch_d;
            ap_valid_q <= ap_valid_d;
            ap_rnw_q   <= ap_rnw_d;
            ap_addr_q  <= ap_addr_d;
            ap_wdata_q <= ap_wdata_d;
        end
    end

    assign swdio_oe     = oe_q;
    assign swdio_out    = out_q;
    assign protocol_err = perr_q;
    assign ap_valid     = ap_valid_q;
    assign ap_rnw       = ap_rnw_q;
    assign ap_addr      = ap_addr_q;
    assign ap_wdata     = ap_wdata_q;
endmodule

// File: tb/tb_swd_target_responder.sv
// Probe-side bench for swd_target_responder: drives SWD frames bit by bit and checks against a
// transaction-level model of the DP registers and AP port. Honours SWD_TGT_STICKY_ERR_EN.
module tb_swd_target_responder;
`ifdef SWD_TGT_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam logic [31:0] IDCODE = 32'h2BA01477;

    logic        swclk = 1'b0, rst = 1'b1, swdio_in = 1'b0;
    logic        swdio_out, swdio_oe, ap_valid, ap_rnw, protocol_err;
    logic        ap_ready = 1'b1;
    logic [7:0]  ap_addr;
    logic [31:0] ap_wdata;
    logic [31:0] ap_rdata = '0;

    int n_errors = 0, n_checks = 0;

    // model state
    logic [31:0] m_ctrl, m_select, m_rdbuf, m_last;
    logic        m_sticky, m_pend;
    int          m_wr_cnt;

    // AP slave: records completed writes
    int          wr_cnt = 0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    swd_target_responder dut (
        .swclk(swclk), .rst(rst), .swdio_in(swdio_in), .swdio_out(swdio_out), .swdio_oe(swdio_oe),
        .ap_valid(ap_valid), .ap_ready(ap_ready), .ap_rnw(ap_rnw), .ap_addr(ap_addr),
        .ap_wdata(ap_wdata), .ap_rdata(ap_rdata), .protocol_err(protocol_err)
    );

    always #5 swclk = ~swclk;

    always @(posedge swclk) begin
        if (ap_valid && ap_ready && !ap_rnw) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= ap_addr;
            wr_data <= ap_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic din);
        swdio_in = din;
        @(posedge swclk);
        #1;
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_select = '0; m_rdbuf = '0; m_last = '0; m_sticky = 1'b0; m_pend = 1'b0;
    endtask

    task automatic line_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
        step(1'b0);
        step(1'b0);
    endtask

    // One complete SWD transfer, with expectations taken from the model.
    task automatic op(input string tag, input logic apndp, input logic rnw, input logic [1:0] a,
                      input logic [31:0] wdata, input logic bad_par);
        logic [7:0]  req;
        logic [2:0]  ack, exp_ack;
        logic [31:0] rd, exp_rd;
        logic        rpar, oe_ok, exempt;
        ap_rdata = $urandom;
        exempt = !apndp && ((rnw && !a[1]) || (!rnw && a == 2'd0));
        if (m_pend)                          exp_ack = 3'b010;
        else if (STICKY && m_sticky && !exempt) exp_ack = 3'b100;
        else                                 exp_ack = 3'b001;
        exp_rd = '0;
        if (exp_ack == 3'b001 && rnw) begin
            if (apndp) begin
                exp_rd = m_rdbuf;
                if (ap_ready) m_rdbuf = ap_rdata;
                else          m_pend = 1'b1;
            end else begin
                case (a)
                    2'd0: exp_rd = IDCODE;
                    2'd1: exp_rd = m_ctrl | (32'(m_sticky) << 7);
                    2'd2: exp_rd = m_last;
                    default: exp_rd = m_rdbuf;
                endcase
            end
            m_last = exp_rd;
        end

        req = {1'b1, 1'b0, apndp ^ rnw ^ a[0] ^ a[1], a[1], a[0], rnw, apndp, 1'b1};
        for (int i = 0; i < 8; i++) step(req[i]);
        oe_ok = 1'b1;
        rd = '0;
        rpar = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            ack[i] = swdio_out;
            oe_ok &= swdio_oe;
        end
        if (ack == 3'b001 && rnw) begin
            for (int i = 0; i < 32; i++) begin
                step(1'b0);
                rd[i] = swdio_out;
                oe_ok &= swdio_oe;
            end
            step(1'b0);
            rpar = swdio_out;
            oe_ok &= swdio_oe;
            step(1'b0);
            chk({tag, "_release"}, 32'(swdio_oe), 32'd0);
            step(1'b0);
        end else begin
            step(1'b0);
            step(1'b0);
            if (ack == 3'b001) begin
                for (int i = 0; i < 32; i++) step(wdata[i]);
                step((^wdata) ^ bad_par);
            end
        end
        for (int i = 0; i < 3; i++) step(1'b0);

        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        chk({tag, "_oe_drive"}, 32'(oe_ok), 32'd1);
        chk({tag, "_oe_idle"}, 32'(swdio_oe), 32'd0);
        if (exp_ack == 3'b001 && rnw) begin
            chk({tag, "_data"}, rd, exp_rd);
            chk({tag, "_parity"}, 32'(rpar), 32'(^exp_rd));
        end

        if (exp_ack == 3'b001 && !rnw) begin
            if (bad_par) begin
                if (STICKY) m_sticky = 1'b1;
            end else if (apndp) begin
                m_wr_cnt++;
                chk({tag, "_apw_addr"}, 32'(wr_addr), 32'({m_select[7:4], a, 2'b00}));
                chk({tag, "_apw_data"}, wr_data, wdata);
            end else begin
                case (a)
                    2'd0: if (wdata[0]) m_sticky = 1'b0;
                    2'd1: m_ctrl = (wdata & 32'h5000_0000) | ((wdata & 32'h5000_0000) << 1);
                    2'd2: m_select = wdata;
                    default: ;
                endcase
            end
        end
        chk({tag, "_apw_count"}, 32'(wr_cnt), 32'(m_wr_cnt));
    endtask

    initial begin
        logic [7:0]  req;
        logic        oe_seen;
        m_wr_cnt = 0;
        model_reset();
        repeat (3) @(posedge swclk);
        #1;
        chk("reset_outputs", 32'({swdio_oe, swdio_out, ap_valid, protocol_err}), 32'd0);
        rst = 1'b0;

        // line reset and IDCODE read
        for (int i = 0; i < 64; i++) step(1'b1);
        step(1'b0);
        step(1'b0);
        op("idcode", 1'b0, 1'b1, 2'd0, '0, 1'b0);

        // posted AP read with a stalled AP
        op("wr_select", 1'b0, 1'b0, 2'd2, 32'h0000_00F0, 1'b0);
        ap_ready = 1'b0;
        op("ap_rd_stall", 1'b1, 1'b1, 2'd0, '0, 1'b0);
        chk("ap_valid_up", 32'(ap_valid), 32'd1);
        chk("ap_addr_f0", 32'(ap_addr), 32'h0000_00F0);
        chk("ap_rnw_rd", 32'(ap_rnw), 32'd1);
        op("ap_rd_wait", 1'b1, 1'b1, 2'd0, '0, 1'b0);
        chk("ap_addr_held", 32'(ap_addr), 32'h0000_00F0);
        ap_rdata = 32'hDEADBEEF;
        ap_ready = 1'b1;
        step(1'b0);
        step(1'b0);
        m_rdbuf = 32'hDEADBEEF;
        m_pend = 1'b0;
        chk("ap_valid_drop", 32'(ap_valid), 32'd0);
        op("rdbuff", 1'b0, 1'b1, 2'd3, '0, 1'b0);
        op("resend", 1'b0, 1'b1, 2'd2, '0, 1'b0);

        // CTRL/STAT write and readback
        op("wr_ctrl", 1'b0, 1'b0, 2'd1, 32'h5000_0000, 1'b0);
        op("rd_ctrl", 1'b0, 1'b1, 2'd1, '0, 1'b0);
        chk("ctrl_value", m_last, 32'hF000_0000);

        // write-data parity error, sticky handling
        op("bad_wpar", 1'b0, 1'b0, 2'd2, 32'h0000_0030, 1'b1);
        op("ap_rd_after_bad", 1'b1, 1'b1, 2'd1, '0, 1'b0);
        op("rd_ctrl_sticky", 1'b0, 1'b1, 2'd1, '0, 1'b0);
        op("abort", 1'b0, 1'b0, 2'd0, 32'h0000_0001, 1'b0);
        op("ap_rd_after_abort", 1'b1, 1'b1, 2'd1, '0, 1'b0);
        op("ap_wr", 1'b1, 1'b0, 2'd3, 32'hCAFE_0123, 1'b0);

        // request with bad parity locks the target out
        req = 8'hA5 ^ 8'h20;
        for (int i = 0; i < 8; i++) step(req[i]);
        chk("perr_pulse", 32'(protocol_err), 32'd1);
        step(1'b0);
        chk("perr_clear", 32'(protocol_err), 32'd0);
        req = 8'hA5;
        oe_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(i < 8 ? req[i] : 1'b0);
            oe_seen |= swdio_oe;
        end
        chk("lockout_quiet", 32'(oe_seen), 32'd0);
        line_reset(50);
        op("idcode_after_lock", 1'b0, 1'b1, 2'd0, '0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic        r_ap, r_rnw, r_bad;
            logic [1:0]  r_a;
            logic [31:0] r_w;
            r_ap  = 1'($urandom_range(0, 1));
            r_rnw = 1'($urandom_range(0, 1));
            r_a   = 2'($urandom_range(0, 3));
            r_w   = $urandom;
            r_bad = !r_rnw && ($urandom_range(0, 7) == 0);
            op($sformatf("rnd%0d", n), r_ap, r_rnw, r_a, r_w, r_bad);
        end

        // asynchronous reset in the middle of a read data phase
        for (int i = 0; i < 8; i++) step(req[i]);
        for (int i = 0; i < 3 + 11; i++) step(1'b0);
        chk("pre_rst_drive", 32'(swdio_oe), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_oe_async", 32'(swdio_oe), 32'd0);
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        model_reset();
        chk("rst_outputs", 32'({swdio_oe, swdio_out, ap_valid, protocol_err}), 32'd0);
        oe_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(i < 8 ? req[i] : 1'b0);
            oe_seen |= swdio_oe;
        end
        chk("post_rst_quiet", 32'(oe_seen), 32'd0);
        line_reset(50);
        op("idcode_after_rst", 1'b0, 1'b1, 2'd0, '0, 1'b0);
        op("ctrl_after_rst", 1'b0, 1'b1, 2'd1, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
